// File: rtl/note_pkg.sv
// Shared types and constants for the note synthesiser: note code layout,
// envelope state encoding and the phase-increment table (220 Hz base, 48 kHz).
package note_pkg;

  localparam int NUM_NOTES = 22;

  typedef struct packed {
    logic       present;
    logic [4:0] num;
  } note_code_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  // round(220 * 2^(k/12) * 2^24 / 48000)
  localparam logic [23:0] PINC_TABLE [NUM_NOTES] = '{
    24'd76896,  24'd81468,  24'd86312,  24'd91445,  24'd96882,  24'd102643,
    24'd108747, 24'd115213, 24'd122064, 24'd129322, 24'd137012, 24'd145160,
    24'd153791, 24'd162936, 24'd172625, 24'd182890, 24'd193765, 24'd205287,
    24'd217494, 24'd230426, 24'd244128, 24'd258645
  };

  function automatic logic note_is_on(input note_code_t code);
    return code.present && (code.num < 5'(NUM_NOTES));
  endfunction

endpackage

// File: rtl/note_synth_env.sv
// Envelope generator: attack/sustain/release FSM stepping the 8-bit amplitude
// once per audio sample tick.
//
//   state   | meaning
//   IDLE    | silent, amp = 0, waiting for gate
//   ATTACK  | amp rising by ENV_STEP per tick, saturating at 255
//   SUSTAIN | amp held at 255 while gate stays high
//   RELEASE | amp falling by ENV_STEP per tick, saturating at 0
module note_synth_env
  import note_pkg::*;
#(
  parameter int ENV_STEP = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_gate,
  output logic [7:0] o_amp,
  output logic       o_busy
);

  env_state_t r_state;
  logic [7:0] r_amp;
  logic       r_busy;
  logic [8:0] w_amp_up;
  logic [7:0] w_amp_up_sat;
  logic [7:0] w_amp_dn_sat;

  assign w_amp_up     = {1'b0, r_amp} + 9'(ENV_STEP);
  assign w_amp_up_sat = (w_amp_up > 9'd255) ? 8'd255 : w_amp_up[7:0];
  assign w_amp_dn_sat = (r_amp > 8'(ENV_STEP)) ? (r_amp - 8'(ENV_STEP)) : 8'd0;

  // Leaving IDLE applies the first attack step on the same tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_amp   <= 8'd0;
      r_busy  <= 1'b0;
    end else if (i_tick) begin
      case (r_state)
        IDLE: begin
          if (i_gate) begin
            r_state <= ATTACK;
            r_amp   <= w_amp_up_sat;
            r_busy  <= 1'b1;
          end
        end
        ATTACK: begin
          if (!i_gate) begin
            r_state <= RELEASE;
          end else begin
            r_amp <= w_amp_up_sat;
            if (w_amp_up_sat == 8'd255) r_state <= SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (!i_gate) r_state <= RELEASE;
        end
        RELEASE: begin
          if (i_gate) begin
            r_state <= ATTACK;
          end else begin
            r_amp <= w_amp_dn_sat;
            if (w_amp_dn_sat == 8'd0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_amp   <= 8'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_amp  = r_amp;
  assign o_busy = r_busy;

endmodule

// File: rtl/note_synth.sv
// Single-voice note synthesiser: sample tick, phase accumulator, square (or,
// with NOTE_SYNTH_TRI_EN defined, triangle) waveform scaled by the envelope.
module note_synth
  import note_pkg::*;
#(
  parameter int SAMPLE_DIV = 2083,
  parameter int ENV_STEP   = 4,
  parameter int PHASE_W    = 24
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [5:0]  note_in,
  input  logic        note_valid_in,
  output logic [15:0] sample_out,
  output logic        sample_valid_out,
  output logic        busy_out
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CNT_W-1:0]   r_tick_cnt;
  logic               w_tick;
  note_code_t         w_note;
  logic               w_note_on;
  logic               r_gate;
  logic [PHASE_W-1:0] r_pending_pinc;
  logic [PHASE_W-1:0] r_active_pinc;
  logic [PHASE_W-1:0] r_phase;
  logic               r_tick_d1;
  logic [7:0]         w_amp;
  logic               w_busy;
  logic signed [15:0] w_raw;
  logic signed [24:0] w_raw_ext;
  logic signed [24:0] w_amp_ext;
  logic signed [24:0] w_prod;

  assign w_tick    = (r_tick_cnt == CNT_W'(SAMPLE_DIV - 1));
  assign w_note    = note_in;
  assign w_note_on = note_is_on(w_note);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  // Invalid or absent notes only drop the gate; the last pitch is kept for release.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_gate         <= 1'b0;
      r_pending_pinc <= '0;
    end else if (note_valid_in) begin
      r_gate <= w_note_on;
      if (w_note_on) r_pending_pinc <= PHASE_W'(PINC_TABLE[w_note.num]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_active_pinc <= '0;
      r_phase       <= '0;
    end else if (w_tick) begin
      r_active_pinc <= r_pending_pinc;
      r_phase       <= w_busy ? (r_phase + r_active_pinc) : '0;
    end
  end

  note_synth_env #(
    .ENV_STEP(ENV_STEP)
  ) u_env (
    .i_clk  (clk_in),
    .i_rst_n(rst_n_in),
    .i_tick (w_tick),
    .i_gate (r_gate),
    .o_amp  (w_amp),
    .o_busy (w_busy)
  );

`ifdef NOTE_SYNTH_TRI_EN
  logic [15:0] w_tri;
  assign w_tri = r_phase[PHASE_W-1] ? ~r_phase[PHASE_W-2 -: 16] : r_phase[PHASE_W-2 -: 16];
  assign w_raw = signed'(w_tri ^ 16'h8000);
`else
  assign w_raw = r_phase[PHASE_W-1] ? 16'sh8000 : 16'sh7fff;
`endif

  assign w_raw_ext = 25'(w_raw);
  assign w_amp_ext = 25'(signed'({1'b0, w_amp}));
  assign w_prod    = w_raw_ext * w_amp_ext;

  // Envelope and phase settle on the tick edge; the product is captured one cycle later.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tick_d1        <= 1'b0;
      sample_valid_out <= 1'b0;
      sample_out       <= '0;
    end else begin
      r_tick_d1        <= w_tick;
      sample_valid_out <= r_tick_d1;
      if (r_tick_d1) sample_out <= w_busy ? 16'(w_prod >>> 8) : 16'd0;
    end
  end

  assign busy_out = w_busy;

endmodule
